// File: rtl/vedic_pkg.sv
// -----------------------------------------------------------------------------
// vedic_pkg
// Shared definitions for the Vedic (Urdhva-Tiryagbhyam) multiplier family.
//   VEDIC_BASE_W : default leaf width where the recursive decomposition stops.
//   prod_w(w)    : width of the product of two w-bit unsigned operands.
//   vedic_2x2()  : the 2x2 Vedic cell used at the bottom of the recursion.
// -----------------------------------------------------------------------------
package vedic_pkg;

    localparam int unsigned VEDIC_BASE_W = 2;

    function automatic int unsigned prod_w(input int unsigned w);
        return 2 * w;
    endfunction

    // Vertical a0*b0, crosswise a1*b0 + a0*b1, vertical a1*b1. The crosswise
    // carry folds into the upper vertical term; the last carry is bit 3.
    function automatic logic [3:0] vedic_2x2(input logic [1:0] a, input logic [1:0] b);
        logic v0;
        logic x0;
        logic x1;
        logic v1;
        logic cross_c;
        v0      = a[0] & b[0];
        x0      = a[1] & b[0];
        x1      = a[0] & b[1];
        v1      = a[1] & b[1];
        cross_c = x0 & x1;
        return {v1 & cross_c, v1 ^ cross_c, x0 ^ x1, v0};
    endfunction

endpackage

// File: rtl/vedic_mult_core.sv
// -----------------------------------------------------------------------------
// vedic_mult_core
// Purely combinational unsigned W x W multiplier built by recursive
// Urdhva-Tiryagbhyam decomposition: four W/2 x W/2 cores and a recombination
// adder, bottoming out at the 2x2 Vedic cell.
// Ports:
//   a, b : W-bit unsigned operands
//   p    : 2*W-bit unsigned product
// -----------------------------------------------------------------------------
module vedic_mult_core
    import vedic_pkg::*;
#(
    parameter int unsigned W      = 4,
    parameter int unsigned BASE_W = VEDIC_BASE_W
) (
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    output logic [prod_w(W)-1:0] p
);

    localparam int unsigned PW = prod_w(W);

    if (W <= BASE_W) begin : g_leaf
        if (W == 2) begin : g_cell
            assign p = vedic_2x2(a, b);
        end else begin : g_plain
            // Only reached if a caller picks a leaf width other than 2.
            assign p = PW'(a) * PW'(b);
        end
    end else begin : g_split
        localparam int unsigned H = W / 2;

        logic [W-1:0] ll;
        logic [W-1:0] lh;
        logic [W-1:0] hl;
        logic [W-1:0] hh;
        logic [W:0]   mid;

        vedic_mult_core #(.W(H), .BASE_W(BASE_W)) u_ll (
            .a (a[H-1:0]),
            .b (b[H-1:0]),
            .p (ll)
        );
        vedic_mult_core #(.W(H), .BASE_W(BASE_W)) u_lh (
            .a (a[H-1:0]),
            .b (b[W-1:H]),
            .p (lh)
        );
        vedic_mult_core #(.W(H), .BASE_W(BASE_W)) u_hl (
            .a (a[W-1:H]),
            .b (b[H-1:0]),
            .p (hl)
        );
        vedic_mult_core #(.W(H), .BASE_W(BASE_W)) u_hh (
            .a (a[W-1:H]),
            .b (b[W-1:H]),
            .p (hh)
        );

        // Crosswise terms share the same weight; keep their carry.
        assign mid = {1'b0, lh} + {1'b0, hl};
        assign p   = {hh, ll} + ({{(W - 1){1'b0}}, mid} << H);
    end

endmodule

// File: rtl/vedic_mult_pipe.sv
// -----------------------------------------------------------------------------
// vedic_mult_pipe
// Three-stage pipelined WIDTH x WIDTH Vedic multiplier with per-transaction
// unsigned / two's-complement mode and valid/ready handshakes on both sides.
//   S0: operand magnitudes and result sign
//   S1: four half-width partial products (vedic_mult_core)
//   S2: recombination, sign application, registered product
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid / in_ready   : operand handshake
//   a, b                  : WIDTH-bit operands
//   signed_mode           : 1 = operands are two's complement
//   out_valid / out_ready : product handshake
//   p                     : 2*WIDTH-bit product
// -----------------------------------------------------------------------------
module vedic_mult_pipe
    import vedic_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned BASE_W = VEDIC_BASE_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic                     signed_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [prod_w(WIDTH)-1:0] p
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned PW   = prod_w(WIDTH);

    // Held low through reset so in_ready only rises on the first edge after it.
    logic alive_q;

    logic             s0_valid_q;
    logic [WIDTH-1:0] s0_ma_q;
    logic [WIDTH-1:0] s0_mb_q;
    logic             s0_neg_q;

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_ll_q;
    logic [WIDTH-1:0] s1_lh_q;
    logic [WIDTH-1:0] s1_hl_q;
    logic [WIDTH-1:0] s1_hh_q;
    logic             s1_neg_q;

    logic             out_valid_q;
    logic [PW-1:0]    p_q;

    logic             s2_ready;
    logic             s1_ready;
    logic             s0_ready;
    logic             accept;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             neg_in;

    logic [WIDTH-1:0] ll;
    logic [WIDTH-1:0] lh;
    logic [WIDTH-1:0] hl;
    logic [WIDTH-1:0] hh;

    logic [WIDTH:0]   mid;
    logic [PW-1:0]    sum;
    logic [PW-1:0]    p_d;

    // A stage can load when it is empty or its contents move on this cycle.
    assign s2_ready = !out_valid_q || out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign s0_ready = !s0_valid_q || s1_ready;
    assign in_ready = alive_q && s0_ready;
    assign accept   = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign p         = p_q;

    // S0 input side: magnitudes fit in WIDTH bits unsigned, including
    // -2^(WIDTH-1) whose magnitude is exactly 2^(WIDTH-1).
    always_comb begin
        a_mag  = a;
        b_mag  = b;
        neg_in = 1'b0;
        if (signed_mode) begin
            if (a[WIDTH-1]) a_mag = -a;
            if (b[WIDTH-1]) b_mag = -b;
            neg_in = a[WIDTH-1] ^ b[WIDTH-1];
        end
    end

    vedic_mult_core #(.W(HALF), .BASE_W(BASE_W)) u_core_ll (
        .a (s0_ma_q[HALF-1:0]),
        .b (s0_mb_q[HALF-1:0]),
        .p (ll)
    );
    vedic_mult_core #(.W(HALF), .BASE_W(BASE_W)) u_core_lh (
        .a (s0_ma_q[HALF-1:0]),
        .b (s0_mb_q[WIDTH-1:HALF]),
        .p (lh)
    );
    vedic_mult_core #(.W(HALF), .BASE_W(BASE_W)) u_core_hl (
        .a (s0_ma_q[WIDTH-1:HALF]),
        .b (s0_mb_q[HALF-1:0]),
        .p (hl)
    );
    vedic_mult_core #(.W(HALF), .BASE_W(BASE_W)) u_core_hh (
        .a (s0_ma_q[WIDTH-1:HALF]),
        .b (s0_mb_q[WIDTH-1:HALF]),
        .p (hh)
    );

    // S2 recombination; negating a zero magnitude yields zero, never -0.
    always_comb begin
        mid = {1'b0, s1_lh_q} + {1'b0, s1_hl_q};
        sum = {s1_hh_q, s1_ll_q} + ({{(WIDTH - 1){1'b0}}, mid} << HALF);
        p_d = sum;
        if (s1_neg_q) p_d = -sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
            s0_ma_q    <= '0;
            s0_mb_q    <= '0;
            s0_neg_q   <= 1'b0;
        end else if (s0_ready) begin
            s0_valid_q <= accept;
            if (accept) begin
                s0_ma_q  <= a_mag;
                s0_mb_q  <= b_mag;
                s0_neg_q <= neg_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_ll_q    <= '0;
            s1_lh_q    <= '0;
            s1_hl_q    <= '0;
            s1_hh_q    <= '0;
            s1_neg_q   <= 1'b0;
        end else if (s1_ready) begin
            s1_valid_q <= s0_valid_q;
            if (s0_valid_q) begin
                s1_ll_q  <= ll;
                s1_lh_q  <= lh;
                s1_hl_q  <= hl;
                s1_hh_q  <= hh;
                s1_neg_q <= s0_neg_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            p_q         <= '0;
        end else if (s2_ready) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                p_q <= p_d;
            end
        end
    end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// -----------------------------------------------------------------------------
// tb_vedic_mult_pipe
// Drives three instances (WIDTH = 8, 4, 16) of vedic_mult_pipe. A queue-based
// scoreboard predicts every product from integer arithmetic on the accepted
// operands; a single negedge process compares outputs in order.
// -----------------------------------------------------------------------------
module tb_vedic_mult_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // WIDTH = 8 instance, full handshake exercised
    logic        in_valid8, in_ready8, sm8, out_valid8, out_ready8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    // WIDTH = 4 instance, output always ready
    logic        in_valid4, in_ready4, sm4, out_valid4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;
    // WIDTH = 16 instance, output always ready
    logic        in_valid16, in_ready16, sm16, out_valid16;
    logic [15:0] a16, b16;
    logic [31:0] p16;
    logic        always_ready = 1'b1;

    vedic_mult_pipe #(.WIDTH(8)) u_dut8 (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid8), .in_ready (in_ready8),
        .a (a8), .b (b8), .signed_mode (sm8), .out_valid (out_valid8),
        .out_ready (out_ready8), .p (p8)
    );
    vedic_mult_pipe #(.WIDTH(4)) u_dut4 (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid4), .in_ready (in_ready4),
        .a (a4), .b (b4), .signed_mode (sm4), .out_valid (out_valid4),
        .out_ready (always_ready), .p (p4)
    );
    vedic_mult_pipe #(.WIDTH(16)) u_dut16 (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid16), .in_ready (in_ready16),
        .a (a16), .b (b16), .signed_mode (sm16), .out_valid (out_valid16),
        .out_ready (always_ready), .p (p16)
    );

    int errors = 0;
    int checks = 0;
    int pops8  = 0;
    int pops4  = 0;
    int pops16 = 0;

    logic [15:0] q8[$];
    logic [7:0]  q4[$];
    logic [31:0] q16[$];
    logic        stall8 = 1'b0;
    logic [15:0] hold_p8;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Product as plain integer arithmetic, truncated to 2*w bits.
    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] x,
                                            input logic [15:0] y, input logic s);
        longint ix, iy, pr;
        ix = longint'(x);
        iy = longint'(y);
        if (s && x[w-1]) ix = ix - (longint'(1) << w);
        if (s && y[w-1]) iy = iy - (longint'(1) << w);
        pr = ix * iy;
        return 32'(pr & ((longint'(1) << (2 * w)) - 1));
    endfunction

    // Single compare process: pop-check before push so same-cycle
    // accept/drain is handled in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            q8.delete();
            q4.delete();
            q16.delete();
            stall8 = 1'b0;
            check("rst_out_valid", 32'(out_valid8), 32'd0);
            check("rst_p", 32'(p8), 32'd0);
            check("rst_in_ready", 32'(in_ready8), 32'd0);
        end else begin
            if (stall8) begin
                check("hold_out_valid", 32'(out_valid8), 32'd1);
                check("hold_p", 32'(p8), 32'(hold_p8));
            end
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) check("unexpected_out8", 32'(out_valid8), 32'd0);
                else begin
                    check("p8", 32'(p8), 32'(q8.pop_front()));
                    pops8++;
                end
            end
            stall8  = out_valid8 && !out_ready8;
            hold_p8 = p8;
            if (in_valid8 && in_ready8)
                q8.push_back(16'(ref_mul(8, {8'b0, a8}, {8'b0, b8}, sm8)));

            if (out_valid4) begin
                if (q4.size() == 0) check("unexpected_out4", 32'(out_valid4), 32'd0);
                else begin
                    check("p4", 32'(p4), 32'(q4.pop_front()));
                    pops4++;
                end
            end
            if (in_valid4 && in_ready4)
                q4.push_back(8'(ref_mul(4, {12'b0, a4}, {12'b0, b4}, sm4)));

            if (out_valid16) begin
                if (q16.size() == 0) check("unexpected_out16", 32'(out_valid16), 32'd0);
                else begin
                    check("p16", p16, q16.pop_front());
                    pops16++;
                end
            end
            if (in_valid16 && in_ready16)
                q16.push_back(ref_mul(16, a16, b16, sm16));
        end
    end

    task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic s);
        int n;
        a8 = x; b8 = y; sm8 = s; in_valid8 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("send8_timeout", 32'(in_ready8), 32'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic single8(input string name, input logic [7:0] x, input logic [7:0] y,
                           input logic s, input logic [15:0] exp);
        int n;
        send8(x, y, s);
        n = 0;
        @(negedge clk);
        while (!out_valid8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(p8), 32'(exp));
    endtask

    task automatic single16(input string name, input logic [15:0] x, input logic [15:0] y,
                            input logic s, input logic [31:0] exp);
        int n;
        a16 = x; b16 = y; sm16 = s; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid16 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, p16, exp);
    endtask

    task automatic drain8();
        int n;
        n = 0;
        while ((q8.size() != 0 || out_valid8) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain8_empty", 32'(q8.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int accepted;
        int seen;
        int pop_start;
        rst_n = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0; out_ready8 = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; sm16 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("in_ready_at_release", 32'(in_ready8), 32'd0);
        @(posedge clk); #1;
        check("in_ready_after_edge", 32'(in_ready8), 32'd1);

        // Latency: counting the accepting edge, out_valid rises on the third edge.
        a8 = 8'hFF; b8 = 8'hFF; sm8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check("lat_edge1_valid", 32'(out_valid8), 32'd0);
        @(posedge clk); #1;
        check("lat_edge2_valid", 32'(out_valid8), 32'd0);
        @(posedge clk); #1;
        check("lat_edge3_valid", 32'(out_valid8), 32'd1);
        check("lat_p_ff_ff", 32'(p8), 32'h0000_FE01);
        drain8();

        single8("s_80_80", 8'h80, 8'h80, 1'b1, 16'h4000);
        single8("s_ff_7f", 8'hFF, 8'h7F, 1'b1, 16'hFF81);
        single8("s_00_80", 8'h00, 8'h80, 1'b1, 16'h0000);
        single8("u_80_80", 8'h80, 8'h80, 1'b0, 16'h4000);
        single8("s_ff_ff", 8'hFF, 8'hFF, 1'b1, 16'h0001);
        single8("s_7f_80", 8'h7F, 8'h80, 1'b1, 16'hC080);
        drain8();

        // Random back-to-back stream with mixed modes.
        pop_start = pops8;
        for (int i = 0; i < 256; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
            in_valid8 = 1'b1;
            @(negedge clk);
            check("stream_in_ready", 32'(in_ready8), 32'd1);
            @(posedge clk); #1;
        end
        in_valid8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("stream_one_per_cycle", 32'(pops8 - pop_start), 32'd256);
        drain8();

        // Backpressure: five stalled cycles fill exactly three stages.
        out_ready8 = 1'b0;
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
            in_valid8 = 1'b1;
            @(negedge clk);
            if (in_ready8) accepted++;
            @(posedge clk); #1;
        end
        check("stall_accepted", 32'(accepted), 32'd3);
        check("stall_in_ready", 32'(in_ready8), 32'd0);
        // Release while still streaming so accept and drain overlap.
        out_ready8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid8 = 1'b0;
        drain8();

        // Reset with two products in flight.
        send8(8'h12, 8'h34, 1'b0);
        send8(8'h9A, 8'h56, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid8), 32'd0);
        check("midrst_p", 32'(p8), 32'd0);
        check("midrst_in_ready", 32'(in_ready8), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid8) seen++;
        end
        check("no_stale_after_reset", 32'(seen), 32'd0);

        // WIDTH = 4 exhaustive, both modes.
        pop_start = pops4;
        single16("w16_u_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++) begin
                    a4 = 4'(x); b4 = 4'(y); sm4 = 1'(s); in_valid4 = 1'b1;
                    @(posedge clk); #1;
                end
        in_valid4 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("w4_all_products", 32'(pops4 - pop_start), 32'd512);
        check("w4_queue_empty", 32'(q4.size()), 32'd0);

        // WIDTH = 16 corners and random traffic.
        single16("w16_s_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000);
        single16("w16_s_8000_8000", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        single16("w16_s_0000_8000", 16'h0000, 16'h8000, 1'b1, 32'h0000_0000);
        for (int i = 0; i < 200; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom);
            in_valid16 = 1'b1;
            @(posedge clk); #1;
        end
        in_valid16 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("w16_queue_empty", 32'(q16.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vedic_mult_pipe.md
Name: vedic_mult_pipe

Overview:
Parametrised, pipelined successor to the 4x4 combinational Vedic multiplier. It multiplies two WIDTH-bit operands using recursive Urdhva-Tiryagbhyam decomposition and supports an unsigned or two's-complement mode per transaction. Operands enter through a valid/ready handshake and products leave through another, with full backpressure. It sits in the datapath wherever the 4x4 combinational multiplier was used but WIDTH exceeds 4 or timing needs registers.

Parameters:
WIDTH, 8, operand width in bits; power of two, >= 4; product width is 2*WIDTH.
BASE_W, 2, leaf width at which recursion stops; the leaf is a plain Vedic 2x2 cell.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand pair is present.
in_ready  output  1  block accepts operands this cycle.
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
signed_mode  input  1  1 = a and b are two's complement; 0 = unsigned.
out_valid  output  1  product is present.
out_ready  input  1  downstream accepts the product.
p  output  2*WIDTH  product; two's complement when the transaction's signed_mode was 1.

Behaviour:
- Reset is asynchronous and active-low. While rst_n = 0: all stage valid flags = 0, out_valid = 0, p = 0, in_ready = 0. in_ready rises on the first clk edge after rst_n deasserts.
- An operand pair is accepted on a rising edge with in_valid && in_ready.
- Pipeline has 3 register stages:
  - S0: capture magnitudes |a| and |b| (WIDTH bits unsigned) and neg = signed_mode & (a[MSB] ^ b[MSB]). In unsigned mode the magnitude is the raw operand.
  - S1: four half-width partial products LL, LH, HL, HH from four vedic_mult_core instances; each product is registered at WIDTH bits.
  - S2: sum = HH<<WIDTH + (LH+HL)<<(WIDTH/2) + LL, computed at 2*WIDTH bits. The middle term LH+HL needs WIDTH+1 bits. If neg, the result is two's-complement negated. The result is registered to p.
- Latency: out_valid asserts on the 3rd rising edge after acceptance when there is no backpressure. Throughput is 1 product per cycle.
- Each stage advances when it is empty or its successor advances. The output stage holds when out_valid && !out_ready. in_ready = !S0_valid || S0_advances, so bubbles collapse under stall.
- While out_valid && !out_ready, p and out_valid stay stable.
- Simultaneous accept at input and drain at output in the same cycle is legal and loses no data. Results leave in strict input order.
- Signed corner cases:
  - -2^(WIDTH-1) squared = +2^(2WIDTH-2); this fits and needs no saturation.
  - A zero operand with neg = 1 produces 0, not negative zero.
- Reset mid-operation discards all in-flight products. No output appears for them after reset.
- Mixed signed_mode values back to back are legal; the mode is carried per stage.

Decomposition:
- Shared package vedic_pkg holds:
  - the function for the partial-product recombination width (prod_w(w) = 2*w);
  - the constant VEDIC_BASE_W = 2;
  - the 2x2 Vedic truth as a function used by the leaf.
- Sub-module vedic_mult_core #(W) is purely combinational and unsigned W x W. It recursively instantiates four W/2 cores plus recombination, bottoming out at the 2x2 Vedic cell. vedic_mult_pipe instantiates four cores at WIDTH/2.

Test Plan:
1. WIDTH=8, unsigned, a=0xFF, b=0xFF, out_ready=1 -> p=0xFE01 with out_valid high exactly 3 cycles after accept.
2. Signed, a=0x80, b=0x80 -> p=0x4000; a=0xFF, b=0x7F -> p=0xFF81; a=0x00, b=0x80 -> p=0x0000.
3. Stream 256 random back-to-back pairs with mixed signed_mode and out_ready=1 -> in_ready stays 1, one product per cycle, all products match the reference model in order.
4. Backpressure: hold out_ready=0 for 5 cycles while streaming -> in_ready drops after 3 pairs are buffered, p stays stable, no loss or duplication after release.
5. Reset mid-stream with 2 products in flight -> out_valid=0 and p=0 immediately; no stale product after rst_n rises.
6. WIDTH=4 exhaustive (all 256 pairs, both modes) and WIDTH=16 with corners 0xFFFF*0xFFFF=0xFFFE0001 and signed 0x8000*0x7FFF=0xC0008000.
